// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared types and helpers for the streaming top-N spectral peak tracker.
//   state_e     : tracker FSM states (ACCUM collects bins, PUBLISH marks the
//                 single cycle in which a finished frame is presented)
//   kw_f()      : bin-index width for a given FFT length (at least 1 bit)
//   peak_slot_t : one working-list slot at the default configuration
//                 (W=34, NSAMPLES=1024); the modules build the same
//                 {vld, mag, k} layout locally from their own parameters.
// ---------------------------------------------------------------------------
package fft_pkg;

  typedef enum logic {
    ACCUM   = 1'b0,
    PUBLISH = 1'b1
  } state_e;

  function automatic int kw_f(input int nsamples);
    return (nsamples > 1) ? $clog2(nsamples) : 1;
  endfunction

  localparam int DEF_W  = 34;
  localparam int DEF_KW = kw_f(1024);

  typedef struct packed {
    logic              vld;
    logic [DEF_W-1:0]  mag;
    logic [DEF_KW-1:0] k;
  } peak_slot_t;

endpackage

// File: rtl/peak_list_insert.sv
// ---------------------------------------------------------------------------
// peak_list_insert
// Combinational insert of one candidate bin into a sorted list of NPEAKS
// slots (slot 0 = largest). The candidate lands at the first slot that is
// empty or holds a strictly smaller magnitude; later slots shift down by one
// and the last slot falls off. Equal magnitudes never displace, so the bin
// that arrived first keeps the higher slot.
// Ports:
//   vld_i/mag_i/k_i     current list, slot i at [i*W+:W] / [i*KW+:KW]
//   cand_en_i           candidate is eligible for insertion
//   cand_mag_i/cand_k_i candidate magnitude and bin index
//   vld_o/mag_o/k_o     list after insertion (unchanged if no slot taken)
//   count_o             number of valid slots in the resulting list
// ---------------------------------------------------------------------------
module peak_list_insert #(
  parameter int NPEAKS = 4,
  parameter int W      = 34,
  parameter int KW     = 10,
  parameter int CW     = $clog2(NPEAKS + 1)
) (
  input  logic [NPEAKS-1:0]    vld_i,
  input  logic [NPEAKS*W-1:0]  mag_i,
  input  logic [NPEAKS*KW-1:0] k_i,
  input  logic                 cand_en_i,
  input  logic [W-1:0]         cand_mag_i,
  input  logic [KW-1:0]        cand_k_i,
  output logic [NPEAKS-1:0]    vld_o,
  output logic [NPEAKS*W-1:0]  mag_o,
  output logic [NPEAKS*KW-1:0] k_o,
  output logic [CW-1:0]        count_o
);

  typedef struct packed {
    logic          vld;
    logic [W-1:0]  mag;
    logic [KW-1:0] k;
  } slot_t;

  slot_t             old_s [NPEAKS];
  slot_t             new_s [NPEAKS];
  slot_t             cand_s;
  logic [NPEAKS-1:0] hit;

  // The list is kept sorted non-increasing with all valid slots first, so
  // "candidate beats slot i" is a thermometer: once true at slot i it stays
  // true for every later slot. The insert position is the first set bit,
  // i.e. the slot whose upper neighbour did not hit.
  always_comb begin
    cand_s = '{vld: 1'b1, mag: cand_mag_i, k: cand_k_i};
    for (int i = 0; i < NPEAKS; i++) begin
      old_s[i] = '{vld: vld_i[i], mag: mag_i[i*W +: W], k: k_i[i*KW +: KW]};
      hit[i]   = cand_en_i && (!old_s[i].vld || (cand_mag_i > old_s[i].mag));
    end

    new_s[0] = hit[0] ? cand_s : old_s[0];
    for (int i = 1; i < NPEAKS; i++) begin
      if (!hit[i]) begin
        new_s[i] = old_s[i];
      end else if (!hit[i-1]) begin
        new_s[i] = cand_s;
      end else begin
        new_s[i] = old_s[i-1];
      end
    end

    count_o = '0;
    for (int i = 0; i < NPEAKS; i++) begin
      vld_o[i]         = new_s[i].vld;
      mag_o[i*W +: W]  = new_s[i].mag;
      k_o[i*KW +: KW]  = new_s[i].k;
      count_o          = count_o + CW'(new_s[i].vld);
    end
  end

endmodule

// File: rtl/fft_peak_topn.sv
// ---------------------------------------------------------------------------
// fft_peak_topn
// Streaming top-N spectral peak tracker. One |X|^2 bin arrives per
// mag_valid; the NPEAKS largest bins with index in [K_MIN, K_MAX] are kept
// sorted. When bin NSAMPLES-1 arrives the finished list (including that
// bin) is published and the working list restarts empty.
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   mag          bin magnitude squared, qualified by mag_valid
//   mag_valid    mag holds the next bin of the current frame
//   threshold    minimum magnitude; honoured only when FFT_PEAK_THRESH_EN
//                is defined, otherwise ignored
//   peak_mag     published magnitudes, slot i at [i*W+:W], slot 0 largest
//   peak_k       published bin indices, slot i at [i*KW+:KW]
//   peak_count   number of filled slots in the published list
//   peak_valid   one-cycle pulse, high the cycle after the last bin
// Build option: FFT_PEAK_THRESH_EN adds the magnitude threshold gate.
// Handshake: no backpressure; every cycle with mag_valid high consumes one
// bin, gaps are allowed anywhere and only valid cycles advance the frame.
// The FSM state is visible directly as peak_valid (high only in PUBLISH).
// ---------------------------------------------------------------------------
module fft_peak_topn
  import fft_pkg::*;
#(
  parameter int NSAMPLES = 1024,
  parameter int W        = 34,
  parameter int NPEAKS   = 4,
  parameter int K_MIN    = 1,
  parameter int K_MAX    = NSAMPLES / 2 - 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [W-1:0]                          mag,
  input  logic                                  mag_valid,
  input  logic [W-1:0]                          threshold,
  output logic [NPEAKS*W-1:0]                   peak_mag,
  output logic [NPEAKS*kw_f(NSAMPLES)-1:0]      peak_k,
  output logic [$clog2(NPEAKS+1)-1:0]           peak_count,
  output logic                                  peak_valid
);

  localparam int KW = kw_f(NSAMPLES);
  localparam int CW = $clog2(NPEAKS + 1);

  localparam logic [KW-1:0] K_LAST = KW'(NSAMPLES - 1);
  localparam logic [KW-1:0] K_LO   = KW'(K_MIN);
  localparam logic [KW-1:0] K_HI   = KW'(K_MAX);

  state_e               state_q, state_d;
  logic [KW-1:0]        k_q, k_d;

  logic [NPEAKS-1:0]    wl_vld_q, wl_vld_d;
  logic [NPEAKS*W-1:0]  wl_mag_q, wl_mag_d;
  logic [NPEAKS*KW-1:0] wl_k_q, wl_k_d;

  logic [NPEAKS*W-1:0]  out_mag_q, out_mag_d;
  logic [NPEAKS*KW-1:0] out_k_q, out_k_d;
  logic [CW-1:0]        out_cnt_q, out_cnt_d;

  logic [NPEAKS-1:0]    ins_vld;
  logic [NPEAKS*W-1:0]  ins_mag;
  logic [NPEAKS*KW-1:0] ins_k;
  logic [CW-1:0]        ins_cnt;

  logic                 last_bin;
  logic                 in_range;
  logic                 thr_ok;
  logic                 cand_en;

  assign last_bin = (k_q == K_LAST);
  assign in_range = (k_q >= K_LO) && (k_q <= K_HI);

`ifdef FFT_PEAK_THRESH_EN
  assign thr_ok = (mag >= threshold);
`else
  logic unused_threshold;
  assign unused_threshold = ^threshold;
  assign thr_ok           = 1'b1;
`endif

  assign cand_en = mag_valid && in_range && thr_ok;

  peak_list_insert #(
    .NPEAKS (NPEAKS),
    .W      (W),
    .KW     (KW),
    .CW     (CW)
  ) u_insert (
    .vld_i      (wl_vld_q),
    .mag_i      (wl_mag_q),
    .k_i        (wl_k_q),
    .cand_en_i  (cand_en),
    .cand_mag_i (mag),
    .cand_k_i   (k_q),
    .vld_o      (ins_vld),
    .mag_o      (ins_mag),
    .k_o        (ins_k),
    .count_o    (ins_cnt)
  );

  // The final bin's insert result goes straight into the output registers
  // and the working list is cleared on that same edge. PUBLISH therefore
  // needs no special handling of mag_valid: bin 0 of the next frame meets
  // an empty list exactly as it would in ACCUM.
  always_comb begin
    state_d   = ACCUM;
    k_d       = k_q;
    wl_vld_d  = wl_vld_q;
    wl_mag_d  = wl_mag_q;
    wl_k_d    = wl_k_q;
    out_mag_d = out_mag_q;
    out_k_d   = out_k_q;
    out_cnt_d = out_cnt_q;

    if (mag_valid) begin
      if (last_bin) begin
        k_d       = '0;
        state_d   = PUBLISH;
        out_mag_d = ins_mag;
        out_k_d   = ins_k;
        out_cnt_d = ins_cnt;
        wl_vld_d  = '0;
        wl_mag_d  = '0;
        wl_k_d    = '0;
      end else begin
        k_d      = k_q + KW'(1);
        wl_vld_d = ins_vld;
        wl_mag_d = ins_mag;
        wl_k_d   = ins_k;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ACCUM;
      k_q       <= '0;
      wl_vld_q  <= '0;
      wl_mag_q  <= '0;
      wl_k_q    <= '0;
      out_mag_q <= '0;
      out_k_q   <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      wl_vld_q  <= wl_vld_d;
      wl_mag_q  <= wl_mag_d;
      wl_k_q    <= wl_k_d;
      out_mag_q <= out_mag_d;
      out_k_q   <= out_k_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign peak_mag   = out_mag_q;
  assign peak_k     = out_k_q;
  assign peak_count = out_cnt_q;
  assign peak_valid = (state_q == PUBLISH);

endmodule

// File: tb/tb_fft_peak_topn.sv
// ---------------------------------------------------------------------------
// tb_fft_peak_topn
// Two tracker instances share one input stream: K_MAX=3 and K_MAX=7
// (NSAMPLES=8, NPEAKS=3, W=8, K_MIN=1). A reference model collects the
// eligible bins of each frame and, at the last bin, picks the NPEAKS
// largest by repeated maximum search (earliest bin wins ties). Every
// falling edge compares both instances against the model.
// ---------------------------------------------------------------------------
module tb_fft_peak_topn;

  localparam int NS    = 8;
  localparam int W     = 8;
  localparam int NP    = 3;
  localparam int KW    = 3;
  localparam int CW    = 2;
  localparam int K_MIN = 1;
  localparam int RW    = CW + NP * KW + NP * W;

  // ---------------- clock / reset / DUTs ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  mag;
  logic          mag_valid;
  logic [W-1:0]  threshold;

  logic [NP*W-1:0]  p3_mag, p7_mag;
  logic [NP*KW-1:0] p3_k, p7_k;
  logic [CW-1:0]    p3_cnt, p7_cnt;
  logic             p3_vld, p7_vld;

  always #5 clk = ~clk;

  fft_peak_topn #(.NSAMPLES(NS), .W(W), .NPEAKS(NP), .K_MIN(K_MIN), .K_MAX(3)) dut3 (
    .clk(clk), .reset(reset), .mag(mag), .mag_valid(mag_valid), .threshold(threshold),
    .peak_mag(p3_mag), .peak_k(p3_k), .peak_count(p3_cnt), .peak_valid(p3_vld)
  );

  fft_peak_topn #(.NSAMPLES(NS), .W(W), .NPEAKS(NP), .K_MIN(K_MIN), .K_MAX(7)) dut7 (
    .clk(clk), .reset(reset), .mag(mag), .mag_valid(mag_valid), .threshold(threshold),
    .peak_mag(p7_mag), .peak_k(p7_k), .peak_count(p7_cnt), .peak_valid(p7_vld)
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [RW-1:0] exp3_q[$];
  logic [RW-1:0] exp7_q[$];
  logic [RW-1:0] cur3 = '0;
  logic [RW-1:0] cur7 = '0;
  int            m_k = 0;
  int            fr_mag[$];
  int            fr_k[$];
  bit            nxt_pulse = 1'b0;
  bit            nxt_clr   = 1'b0;
  bit            exp_pulse;
  bit            elig;

  // Top-NP of the frame's eligible bins with index <= kmax.
  function automatic logic [RW-1:0] top_rec(input int kmax);
    int              cm[$];
    int              ck[$];
    int              best;
    int              cnt = 0;
    logic [NP*W-1:0]  pm = '0;
    logic [NP*KW-1:0] pk = '0;
    for (int i = 0; i < fr_mag.size(); i++) begin
      if (fr_k[i] <= kmax) begin
        cm.push_back(fr_mag[i]);
        ck.push_back(fr_k[i]);
      end
    end
    for (int s = 0; s < NP; s++) begin
      if (cm.size() == 0) break;
      best = 0;
      for (int j = 1; j < cm.size(); j++) if (cm[j] > cm[best]) best = j;
      pm[s*W +: W]   = W'(cm[best]);
      pk[s*KW +: KW] = KW'(ck[best]);
      cm.delete(best);
      ck.delete(best);
      cnt++;
    end
    return {CW'(cnt), pk, pm};
  endfunction

  // Consumes the inputs that the next rising edge will sample.
  task automatic model_step();
    nxt_pulse = 1'b0;
    nxt_clr   = 1'b0;
    if (reset) begin
      m_k = 0;
      fr_mag.delete();
      fr_k.delete();
      exp3_q.delete();
      exp7_q.delete();
      nxt_clr = 1'b1;
    end else if (mag_valid) begin
      elig = (m_k >= K_MIN);
`ifdef FFT_PEAK_THRESH_EN
      if (mag < threshold) elig = 1'b0;
`endif
      if (elig) begin
        fr_mag.push_back(int'(mag));
        fr_k.push_back(m_k);
      end
      if (m_k == NS - 1) begin
        exp3_q.push_back(top_rec(3));
        exp7_q.push_back(top_rec(7));
        fr_mag.delete();
        fr_k.delete();
        nxt_pulse = 1'b1;
      end
      m_k = (m_k + 1) % NS;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      exp_pulse = nxt_pulse;
      if (nxt_clr) begin
        cur3 = '0;
        cur7 = '0;
      end
      if (exp_pulse) begin
        if (exp3_q.size() > 0) cur3 = exp3_q.pop_front();
        if (exp7_q.size() > 0) cur7 = exp7_q.pop_front();
      end
      chk("pulse3", p3_vld, exp_pulse);
      chk("pulse7", p7_vld, exp_pulse);
      chk("mag3", p3_mag, cur3[NP*W-1:0]);
      chk("k3",   p3_k,   cur3[NP*W +: NP*KW]);
      chk("cnt3", p3_cnt, cur3[RW-1 -: CW]);
      chk("mag7", p7_mag, cur7[NP*W-1:0]);
      chk("k7",   p7_k,   cur7[NP*W +: NP*KW]);
      chk("cnt7", p7_cnt, cur7[RW-1 -: CW]);
      model_step();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] m);
    mag       = m;
    mag_valid = 1'b1;
    @(posedge clk);
    #1;
    mag_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    mag_valid = 1'b0;
    idle(n);
    reset = 1'b0;
  endtask

  int frame1[8] = '{9, 5, 7, 2, 1, 1, 1, 1};
  int frame2[8] = '{0, 4, 4, 6, 4, 1, 1, 1};

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    mag       = '0;
    mag_valid = 1'b0;
    threshold = 8'd6;
    idle(3);
    reset = 1'b0;
    idle(2);

    // Frame 1 back-to-back; pulse and values right after the last bin.
    for (int b = 0; b < NS; b++) send(W'(frame1[b]));
    chk("t1_pulse", p3_vld, 1'b1);
`ifdef FFT_PEAK_THRESH_EN
    chk("t6_mag", p3_mag, {8'd0, 8'd0, 8'd7});
    chk("t6_k",   p3_k,   {3'd0, 3'd0, 3'd2});
    chk("t6_cnt", p3_cnt, 2'd1);
`else
    chk("t1_mag", p3_mag, {8'd2, 8'd5, 8'd7});
    chk("t1_k",   p3_k,   {3'd3, 3'd1, 3'd2});
    chk("t1_cnt", p3_cnt, 2'd3);
`endif
    idle(2);

    // Frame with ties, observed on the K_MAX=7 instance.
    threshold = 8'd0;
    for (int b = 0; b < NS; b++) send(W'(frame2[b]));
    chk("t2_mag", p7_mag, {8'd4, 8'd4, 8'd6});
    chk("t2_k",   p7_k,   {3'd2, 3'd1, 3'd3});

    // Two frames back-to-back, second one all zero except bin 2.
    for (int b = 0; b < NS; b++) send(W'(frame1[b]));
    for (int b = 0; b < NS; b++) send((b == 2) ? 8'd3 : 8'd0);
    chk("t3_mag", p3_mag, {8'd0, 8'd0, 8'd3});
    chk("t3_k",   p3_k,   {3'd3, 3'd1, 3'd2});
    chk("t3_cnt", p3_cnt, 2'd3);
    idle(1);

    // Reset in the middle of a frame, then a fresh frame.
    for (int b = 0; b < 4; b++) send(8'd9);
    mag = 8'd5;
    reset = 1'b1;
    mag_valid = 1'b1;
    idle(2);
    reset = 1'b0;
    mag_valid = 1'b0;
    idle(1);
    for (int b = 0; b < NS; b++) send((b == 1) ? 8'd8 : 8'd0);
    chk("t4_mag", p3_mag, {8'd0, 8'd0, 8'd8});
    chk("t4_k",   p3_k,   {3'd3, 3'd2, 3'd1});
    idle(1);

    // Frame 1 with a gap after every valid.
    threshold = 8'd6;
    for (int b = 0; b < NS; b++) begin
      send(W'(frame1[b]));
      if (b != NS - 1) idle(1);
    end
    chk("t5_pulse", p3_vld, 1'b1);
    idle(2);

    // Random frames with random gaps and thresholds.
    for (int f = 0; f < 40; f++) begin
      threshold = W'($urandom_range(0, 15));
      for (int b = 0; b < NS; b++) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        send(W'($urandom_range(0, 15)));
      end
    end
    idle(3);

    chk("drain3", exp3_q.size(), 0);
    chk("drain7", exp7_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
